// File: rtl/arb_rr_bytes_4f_if.sv
// arb_rr_bytes_4f_if
//   Bundles the requester handshake and the packer-side byte stream of the
//   byte-slot arbiter arb_rr_bytes_4f.
//   Requester side : req_valid[N_REQ], req_data[N_REQ*DATA_W], req_ready[N_REQ]
//   Packer side    : data_out[DATA_W], valid_out, word_start, src_id[ID_W], busy
//   modport slave  : the arbiter (consumes requests, drives the stream)
//   modport master : requesters / packer side environment
interface arb_rr_bytes_4f_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       data_out;
    logic                    valid_out;
    logic                    word_start;
    logic [ID_W-1:0]         src_id;
    logic                    busy;

    modport slave (
        input  req_valid, req_data,
        output req_ready, data_out, valid_out, word_start, src_id, busy
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, data_out, valid_out, word_start, src_id, busy
    );
endinterface

// File: rtl/arb_rr_bytes_4f.sv
// arb_rr_bytes_4f
//   Round-robin scheduler sharing an 8->32 byte packer between N_REQ byte
//   sources. Runs on clk_4f; every BEAT-cycle slot (aligned to clk_f) is owned
//   by one source, chosen at beat 0. Emits the registered byte stream for the
//   packer plus a word-start strobe and the owning source tag.
// Ports
//   clk_4f   : byte clock
//   reset_L  : asynchronous active-low reset
//   bus      : arb_rr_bytes_4f_if.slave
//              req_valid/req_data in, req_ready out (combinational, one-hot),
//              data_out/valid_out/word_start/src_id/busy out (registered)
// Configuration
//   ARB_STRICT_PRIO_EN : when defined, fixed priority (lowest index wins) at
//                        every slot boundary; rr_ptr held at 0.
module arb_rr_bytes_4f #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int BEAT   = 4,
    parameter int ID_W   = 2
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    arb_rr_bytes_4f_if.slave  bus
);
    localparam int CNT_W = (BEAT > 1) ? $clog2(BEAT) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              word_start_q, word_start_d;
    logic [ID_W-1:0]   src_id_q, src_id_d;
    logic              busy_q, busy_d;

    logic              slot_start;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    int unsigned       scan_idx;
    logic              granted;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;

    // Arbitration candidate, evaluated every cycle but only used at beat 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
`ifdef ARB_STRICT_PRIO_EN
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!pick_found && bus.req_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(k);
            end
        end
`else
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!pick_found && bus.req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(scan_idx);
            end
        end
`endif
    end

    // The grant decided at beat 0 takes effect in that same cycle, so the
    // "_d" state/grant double as the effective grant for the current beat.
    always_comb begin
        slot_start = (beat_q == '0);
        beat_d     = (beat_q == CNT_W'(BEAT - 1)) ? '0 : beat_q + 1'b1;

        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        if (slot_start) begin
            if (pick_found) begin
                state_d = GRANT;
                gnt_d   = pick_idx;
`ifdef ARB_STRICT_PRIO_EN
                rr_ptr_d = '0;
`else
                if (pick_idx == ID_W'(N_REQ - 1)) rr_ptr_d = '0;
                else                              rr_ptr_d = pick_idx + 1'b1;
`endif
            end else begin
                state_d = IDLE;
            end
        end

        granted   = (state_d == GRANT);
        sel_valid = bus.req_valid[gnt_d];
        sel_data  = bus.req_data[gnt_d*DATA_W +: DATA_W];

        // Reset gate: the flops sit at beat 0 during reset, which would
        // otherwise look like a live arbitration point.
        bus.req_ready = '0;
        if (granted && sel_valid && reset_L) bus.req_ready[gnt_d] = 1'b1;

        valid_out_d  = granted && sel_valid;
        data_out_d   = valid_out_d ? sel_data : '0;
        word_start_d = slot_start && granted;
        src_id_d     = granted ? gnt_d : src_id_q;
        busy_d       = granted;
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            word_start_q <= 1'b0;
            src_id_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            word_start_q <= word_start_d;
            src_id_q     <= src_id_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.word_start = word_start_q;
    assign bus.src_id     = src_id_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_arb_rr_bytes_4f.sv
// Testbench for arb_rr_bytes_4f: table-driven per-cycle vectors plus
// hand-written reset sequences.
module tb_arb_rr_bytes_4f;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int BEAT   = 4;
    localparam int ID_W   = 2;
`ifdef ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] rd;
        logic [3:0]  rdy;
        logic [7:0]  dout;
        logic        vo;
        logic        ws;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    logic clk_4f  = 1'b0;
    logic reset_L = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vq[$];

    always #5 clk_4f = ~clk_4f;

    arb_rr_bytes_4f_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    arb_rr_bytes_4f #(
        .N_REQ (N_REQ),
        .DATA_W(DATA_W),
        .BEAT  (BEAT),
        .ID_W  (ID_W)
    ) dut (
        .clk_4f (clk_4f),
        .reset_L(reset_L),
        .bus    (bus.slave)
    );

    function automatic logic [31:0] mk(input int lane, input logic [7:0] b);
        logic [31:0] r;
        r = 32'hEEEE_EEEE;
        r[8*lane +: 8] = b;
        return r;
    endfunction

    function automatic void push(input logic [3:0] rv, input logic [31:0] rd,
                                 input logic [3:0] rdy, input logic [7:0] dout,
                                 input logic vo, input logic ws,
                                 input logic [1:0] src, input logic busy);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rdy = rdy; v.dout = dout;
        v.vo = vo; v.ws = ws; v.src = src; v.busy = busy;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Inputs held for one cycle: req_ready checked combinationally, the
    // registered outputs checked just after the closing edge.
    task automatic apply(input vec_t v, input string tag);
        bus.req_valid = v.rv;
        bus.req_data  = v.rd;
        #1;
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(v.rdy));
        @(posedge clk_4f);
        #1;
        chk({tag, " data_out"},   32'(bus.data_out),   32'(v.dout));
        chk({tag, " valid_out"},  32'(bus.valid_out),  32'(v.vo));
        chk({tag, " word_start"}, 32'(bus.word_start), 32'(v.ws));
        chk({tag, " src_id"},     32'(bus.src_id),     32'(v.src));
        chk({tag, " busy"},       32'(bus.busy),       32'(v.busy));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_ready"},  32'(bus.req_ready),  0);
        chk({tag, " data_out"},   32'(bus.data_out),   0);
        chk({tag, " valid_out"},  32'(bus.valid_out),  0);
        chk({tag, " word_start"}, 32'(bus.word_start), 0);
        chk({tag, " src_id"},     32'(bus.src_id),     0);
        chk({tag, " busy"},       32'(bus.busy),       0);
    endtask

    // Reset for 3 cycles with all requests high; release just after an edge
    // so the following cycle is beat 0.
    task automatic do_reset(input string tag);
        reset_L       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hD3C2_B1A0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_4f);
            #1;
            chk_zero($sformatf("%s rst%0d", tag, i));
        end
        reset_L = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int s;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // Single source 1
        push(4'b0010, mk(1, 8'h2F), 4'b0010, 8'h2F, 1, 1, 2'd1, 1);
        push(4'b0010, mk(1, 8'h5E), 4'b0010, 8'h5E, 1, 0, 2'd1, 1);
        push(4'b0010, mk(1, 8'h8D), 4'b0010, 8'h8D, 1, 0, 2'd1, 1);
        push(4'b0010, mk(1, 8'hBC), 4'b0010, 8'hBC, 1, 0, 2'd1, 1);
        // Idle slot: src_id holds, data forced to 0
        for (int i = 0; i < 4; i++)
            push(4'b0000, 32'h1122_3344, 4'b0000, 8'h00, 0, 0, 2'd1, 0);
        // Late request: rises at beat 1 of an idle slot
        push(4'b0000, 32'h0, 4'b0000, 8'h00, 0, 0, 2'd1, 0);
        for (int i = 1; i < 4; i++)
            push(4'b1000, mk(3, 8'h31), 4'b0000, 8'h00, 0, 0, 2'd1, 0);
        push(4'b1000, mk(3, 8'h41), 4'b1000, 8'h41, 1, 1, 2'd3, 1);
        push(4'b1000, mk(3, 8'h42), 4'b1000, 8'h42, 1, 0, 2'd3, 1);
        push(4'b1000, mk(3, 8'h43), 4'b1000, 8'h43, 1, 0, 2'd3, 1);
        push(4'b1000, mk(3, 8'h44), 4'b1000, 8'h44, 1, 0, 2'd3, 1);
        // Contention: five slots with everyone requesting
        for (int k = 0; k < 5; k++) begin
            s = STRICT ? 0 : (k % 4);
            for (int b = 0; b < 4; b++)
                push(4'b1111, 32'hD3C2_B1A0, 4'(1 << s), 8'(8'hA0 + 8'h11 * s),
                     1, (b == 0), 2'(s), 1);
        end
        // Bubble at beat 2 of a source-2 slot, then next slot boundary
        push(4'b0100, mk(2, 8'h51), 4'b0100, 8'h51, 1, 1, 2'd2, 1);
        push(4'b0100, mk(2, 8'h52), 4'b0100, 8'h52, 1, 0, 2'd2, 1);
        push(4'b0000, mk(2, 8'h53), 4'b0000, 8'h00, 0, 0, 2'd2, 1);
        push(4'b0100, mk(2, 8'h54), 4'b0100, 8'h54, 1, 0, 2'd2, 1);
        push(4'b0100, mk(2, 8'h61), 4'b0100, 8'h61, 1, 1, 2'd2, 1);
        for (int i = 0; i < 3; i++)
            push(4'b0000, mk(2, 8'h62), 4'b0000, 8'h00, 0, 0, 2'd2, 1);

        do_reset("init");
        foreach (vq[i]) apply(vq[i], $sformatf("v%0d", i));

        // Reset in beat 2 of a source-1 grant
        do_reset("mid");
        vq.delete();
        push(4'b0010, mk(1, 8'h71), 4'b0010, 8'h71, 1, 1, 2'd1, 1);
        push(4'b0010, mk(1, 8'h72), 4'b0010, 8'h72, 1, 0, 2'd1, 1);
        apply(vq[0], "mid_b0");
        apply(vq[1], "mid_b1");
        reset_L = 1'b0;
        #1;
        chk_zero("mid_abort");
        for (int i = 0; i < 3; i++) @(posedge clk_4f);
        #1;
        reset_L = 1'b1;
        vq.delete();
        for (int k = 0; k < 3; k++) begin
            s = STRICT ? 0 : k;
            for (int b = 0; b < 4; b++)
                push(4'b1111, 32'hD3C2_B1A0, 4'(1 << s), 8'(8'hA0 + 8'h11 * s),
                     1, (b == 0), 2'(s), 1);
        end
        foreach (vq[i]) apply(vq[i], $sformatf("post%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
